frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Sequences guitar ADC samples into the FFT datapath. Takes each completed oversample and optionally decimates it. Writes the result into one half of a ping-pong frame buffer. When a frame fills, it offers that frame to the FFT core over a valid/ready handshake, then holds the bank until the core releases it. Sits between the XADC oversampler and the FFT core/frame RAM, all on the 104 MHz domain.

## Interface
Parameters:
- FRAME_LEN, 1024, samples per frame; power of two, ≥ 4
- SAMPLE_W, 16, sample width
- DECIM, 1, accept every DECIMth sample_valid; 1..255

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  104 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  capture enable
- sample  in  SAMPLE_W  oversampled ADC word
- sample_valid  in  1  one-cycle pulse per new sample (oversampler done)
- wr_en  out  1  frame RAM write strobe
- wr_bank  out  1  bank being written
- wr_addr  out  $clog2(FRAME_LEN)  write address within bank
- wr_data  out  SAMPLE_W  write data
- frame_valid  out  1  a full bank is offered to the FFT
- frame_bank  out  1  bank offered
- frame_ready  in  1  FFT accepts the offered frame
- frame_done  in  1  one-cycle pulse: FFT finished reading its bank
- overflow_cnt  out  8  dropped accepted samples, saturating at 255
- state  out  2  debug: IDLE=0, FILL=1, WAIT=2

## Operation
- Each bank has a status: FREE, FULL or READING. There is a write pointer wb, a read pointer rb and a fill index idx.
- Decimation: a counter advances on each sample_valid while en=1. A sample is accepted when the counter is 0; the counter wraps at DECIM-1. With DECIM=1, every sample is accepted.
- State IDLE:
  - idx=0; no writes.
  - If en=1 and bank wb is FREE → FILL.
  - If en=1 and bank wb is not FREE → WAIT.
- State FILL: each accepted sample is written to (wb, idx), then idx increments.
  - When the sample at idx=FRAME_LEN-1 is written, bank wb becomes FULL, idx wraps to 0 and wb toggles.
  - If the new wb is FREE, the block stays in FILL; otherwise it moves to WAIT.
- State WAIT:
  - Accepted samples are dropped and overflow_cnt increments, saturating.
  - Moves to FILL in the first cycle that bank wb is FREE.
- en=0 in FILL or WAIT → IDLE. The partial frame is discarded (idx=0) and the decimation counter clears. FULL and READING banks are kept.
- Handshake:
  - frame_valid=1 iff bank rb is FULL; frame_bank=rb.
  - When frame_valid and frame_ready are both 1, bank rb becomes READING.
  - On frame_done while bank rb is READING: bank rb becomes FREE and rb toggles.
  - frame_done in any other case is ignored. frame_ready without frame_valid is ignored.
- Simultaneous events:
  - frame_done is applied before the fill-complete check in the same cycle. If the last sample and the other bank's release arrive together, the next state is FILL, not WAIT.
  - A sample write to bank wb never coincides with a read of the same bank; statuses guarantee this.

## Timing
- Reset values: wr_en=0, wr_bank=0, wr_addr=0, wr_data=0, frame_valid=0, frame_bank=0, overflow_cnt=0, state=IDLE. All banks are FREE; wb=rb=0; decimation counter=0.
- All outputs are registered.
- wr_en/wr_addr/wr_data assert 1 cycle after the accepted sample_valid. wr_en is high for exactly 1 cycle per write.
- frame_valid rises 1 cycle after the last write strobe of a frame.
- After an accepted handshake, frame_valid falls in the next cycle.
- A bank freed by frame_done can be written by a sample arriving in the following cycle.
- Reset asserted mid-frame forces the reset values immediately. No partial state survives.

## Structure
- Shared package ghffe_pkg holds:
  - bank status enum (FREE/FULL/READING)
  - sequencer state enum (IDLE/FILL/WAIT)
  - default FRAME_LEN and SAMPLE_W constants
- Sub-module: sample_decimator (DECIM counter; input sample_valid/en, output accept pulse).
- The bank/status logic and FSM live in frame_sequencer.

## Test plan
All scenarios use FRAME_LEN=8 unless noted.
- Reset and fill: DECIM=1, en=1, 8 samples 0x0000..0x0007 → 8 writes on bank 0, addr 0..7; frame_valid=1, frame_bank=0 one cycle after the last write.
- Ping-pong with overflow:
  - Stimulus: ready held 0, 24 samples.
  - Response: banks 0 and 1 FULL; state=WAIT; overflow_cnt=8; frame_bank=0.
  - Then ready=1 and a frame_done pulse → frame_bank=1 is offered and writing resumes on bank 0.
- Simultaneous events:
  - Stimulus: bank 1 READING, the last sample of bank 0 and frame_done arrive in the same cycle.
  - Response: next state=FILL, wb=1, overflow_cnt unchanged.
- Decimation: DECIM=3, 24 sample_valid pulses → exactly 8 writes, taken from pulses 1, 4, 7, …, 22.
- Abort: en dropped after 5 samples → state=IDLE; the next frame starts at addr 0 on the same bank; no frame_valid.
- Saturation and reset: 300 dropped samples → overflow_cnt=255. Then reset_n pulsed low mid-fill → all outputs return to reset values.

Source files
------------

// File: rtl/ghffe_pkg.sv
// Shared types and defaults for the guitar-capture frame sequencer.
package ghffe_pkg;

  localparam int unsigned FRAME_LEN_DEF = 1024;
  localparam int unsigned SAMPLE_W_DEF  = 16;
  localparam int unsigned OVF_W         = 8;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_st_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } seq_st_e;

  // Increment that sticks at all-ones.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/sample_decimator.sv
// Keeps every DECIMth sample_valid pulse while enabled; phase restarts when en drops.
module sample_decimator #(
  parameter int unsigned DECIM = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic sample_valid_i,
  output logic accept_c
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (sample_valid_i) begin
      accept_c = (cnt_q == '0);
      cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// Writes decimated ADC samples into a ping-pong frame RAM and hands full
// banks to the FFT core over a valid/ready + done handshake.
module frame_sequencer
  import ghffe_pkg::*;
#(
  parameter  int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter  int unsigned SAMPLE_W  = SAMPLE_W_DEF,
  parameter  int unsigned DECIM     = 1,
  localparam int unsigned AW        = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [AW-1:0]       wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                frame_valid,
  output logic                frame_bank,
  input  logic                frame_ready,
  input  logic                frame_done,
  output logic [OVF_W-1:0]    overflow_cnt,
  output logic [1:0]          state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  seq_st_e             state_q, state_d;
  bank_st_e            bank_q [2];
  bank_st_e            bank_d [2];
  logic                wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic                wr_en_q, wr_en_d, wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                fv_q, fv_d, fb_q, fb_d;
  logic                fill_done;
  logic                accept_c;

  sample_decimator #(.DECIM(DECIM)) u_decim (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (en),
    .sample_valid_i (sample_valid),
    .accept_c       (accept_c)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fill_done = 1'b0;

    // Read side first, so a release this cycle is visible to the fill decisions below.
    if (fv_q && frame_ready) bank_d[rb_q] = BANK_READING;
    if (frame_done && (bank_q[rb_q] == BANK_READING)) begin
      bank_d[rb_q] = BANK_FREE;
      rb_d         = ~rb_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (en) state_d = (bank_d[wb_q] == BANK_FREE) ? ST_FILL : ST_WAIT;
      end
      ST_FILL: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (accept_c) begin
          wr_en_d   = 1'b1;
          wr_bank_d = wb_q;
          wr_addr_d = idx_q;
          wr_data_d = sample;
          if (idx_q == LAST_IDX) begin
            bank_d[wb_q] = BANK_FULL;
            fill_done    = 1'b1;
            wb_d         = ~wb_q;
            idx_d        = '0;
            state_d      = (bank_d[wb_d] == BANK_FREE) ? ST_FILL : ST_WAIT;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          if (accept_c) ovf_d = sat_inc(ovf_q);
          if (bank_d[wb_q] == BANK_FREE) state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bank filled this cycle is offered only after its last write strobe.
    fv_d = (bank_d[rb_d] == BANK_FULL) && !(fill_done && (wb_q == rb_d));
    fb_d = rb_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bank_q[0] <= BANK_FREE;
      bank_q[1] <= BANK_FREE;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fv_q      <= 1'b0;
      fb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fv_q      <= fv_d;
      fb_q      <= fb_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_valid  = fv_q;
  assign frame_bank   = fb_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two instances (DECIM=1 and DECIM=3) share the
// sample stream; a behavioural model feeds per-cycle and per-write scoreboards.
module tb_frame_sequencer;

  localparam int unsigned FL = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned AW = 3;

  localparam int M_IDLE = 0, M_FILL = 1, M_WAIT = 2;
  localparam int B_FREE = 0, B_FULL = 1, B_RD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, en, sample_valid;
  logic [SW-1:0] sample;
  logic          frame_ready [2];
  logic          frame_done  [2];
  logic          wr_en_w [2], wr_bank_w [2], fv_w [2], fb_w [2];
  logic [AW-1:0] wr_addr_w [2];
  logic [SW-1:0] wr_data_w [2];
  logic [7:0]    ovf_w [2];
  logic [1:0]    state_w [2];

  frame_sequencer #(.FRAME_LEN(FL), .SAMPLE_W(SW), .DECIM(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .sample(sample), .sample_valid(sample_valid),
    .wr_en(wr_en_w[0]), .wr_bank(wr_bank_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
    .frame_valid(fv_w[0]), .frame_bank(fb_w[0]), .frame_ready(frame_ready[0]),
    .frame_done(frame_done[0]), .overflow_cnt(ovf_w[0]), .state(state_w[0])
  );

  frame_sequencer #(.FRAME_LEN(FL), .SAMPLE_W(SW), .DECIM(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .sample(sample), .sample_valid(sample_valid),
    .wr_en(wr_en_w[1]), .wr_bank(wr_bank_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
    .frame_valid(fv_w[1]), .frame_bank(fb_w[1]), .frame_ready(frame_ready[1]),
    .frame_done(frame_done[1]), .overflow_cnt(ovf_w[1]), .state(state_w[1])
  );

  typedef struct packed {
    logic       wr;
    logic       fv;
    logic       fb;
    logic [7:0] ovf;
    logic [1:0] st;
  } cyc_t;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  cyc_t cq [2][$];
  wr_t  wq [2][$];

  int tests = 0;
  int fails = 0;
  int wcnt [2];
  bit chk_on = 1'b0;

  // Reference model state
  int m_st [2][2];
  int m_wb [2], m_rb [2], m_idx [2], m_mode [2], m_pul [2], m_ovf [2], m_fb [2];
  bit m_fv [2];

  // FFT emulation
  int busy [2];
  bit auto_fft = 1'b0;
  bit rdy_ov   = 1'b0;
  bit dn_ov    = 1'b0;
  bit en_prev  = 1'b0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", name, inst, act, exp);
    end
  endtask

  function automatic int dec_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i][0] = B_FREE; m_st[i][1] = B_FREE;
      m_wb[i] = 0; m_rb[i] = 0; m_idx[i] = 0; m_mode[i] = M_IDLE;
      m_pul[i] = 0; m_ovf[i] = 0; m_fv[i] = 1'b0; m_fb[i] = 0;
    end
  endfunction

  // One clock of the reference behaviour; pushes the outputs expected after the edge.
  function automatic void model_step(input int i, input bit e, input bit v,
                                     input logic [SW-1:0] d, input bit rdy, input bit dn);
    bit   acc, wr, comp, was_rd;
    int   fullb;
    cyc_t c;
    wr_t  w;
    acc = 1'b0; wr = 1'b0; comp = 1'b0; fullb = 0;
    if (!e) m_pul[i] = 0;
    else if (v) begin
      acc = ((m_pul[i] % dec_of(i)) == 0);
      m_pul[i]++;
    end
    was_rd = (m_st[i][m_rb[i]] == B_RD);
    if (m_fv[i] && rdy) m_st[i][m_rb[i]] = B_RD;
    if (dn && was_rd) begin
      m_st[i][m_rb[i]] = B_FREE;
      m_rb[i] = 1 - m_rb[i];
    end
    if (!e) begin
      m_mode[i] = M_IDLE;
      m_idx[i]  = 0;
    end else if (m_mode[i] == M_IDLE) begin
      m_idx[i]  = 0;
      m_mode[i] = (m_st[i][m_wb[i]] == B_FREE) ? M_FILL : M_WAIT;
    end else if (m_mode[i] == M_FILL) begin
      if (acc) begin
        wr = 1'b1;
        w.bank = 1'(m_wb[i]);
        w.addr = AW'(m_idx[i]);
        w.data = d;
        wq[i].push_back(w);
        if (m_idx[i] == FL - 1) begin
          m_st[i][m_wb[i]] = B_FULL;
          comp  = 1'b1;
          fullb = m_wb[i];
          m_wb[i]  = 1 - m_wb[i];
          m_idx[i] = 0;
          m_mode[i] = (m_st[i][m_wb[i]] == B_FREE) ? M_FILL : M_WAIT;
        end else begin
          m_idx[i]++;
        end
      end
    end else begin
      if (acc && m_ovf[i] < 255) m_ovf[i]++;
      if (m_st[i][m_wb[i]] == B_FREE) m_mode[i] = M_FILL;
    end
    m_fv[i] = (m_st[i][m_rb[i]] == B_FULL) && !(comp && fullb == m_rb[i]);
    m_fb[i] = m_rb[i];
    c.wr  = wr;
    c.fv  = m_fv[i];
    c.fb  = 1'(m_fb[i]);
    c.ovf = 8'(m_ovf[i]);
    c.st  = 2'(m_mode[i]);
    cq[i].push_back(c);
  endfunction

  // Drive one clock of stimulus and record what both instances should do.
  task automatic cyc(input bit e, input bit v, input logic [SW-1:0] d);
    @(posedge clk);
    #2;
    en = e;
    sample_valid = v;
    sample = d;
    for (int i = 0; i < 2; i++) begin
      bit r, dn;
      r  = rdy_ov;
      dn = dn_ov;
      if (auto_fft) begin
        if (busy[i] > 0) begin
          busy[i]--;
          if (busy[i] == 0) dn = 1'b1;
        end else begin
          r = ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 15) == 0) dn = 1'b1;
          if (m_fv[i] && r) busy[i] = $urandom_range(1, 12);
        end
      end
      frame_ready[i] = r;
      frame_done[i]  = dn;
      model_step(i, e, v, d, r, dn);
    end
    en_prev = e;
    chk_on  = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    chk_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cq[i].delete(); wq[i].delete();
      busy[i] = 0; frame_ready[i] = 1'b0; frame_done[i] = 1'b0;
    end
    en = 1'b0; sample_valid = 1'b0; sample = '0; en_prev = 1'b0;
    rdy_ov = 1'b0; dn_ov = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr_en",   i, int'(wr_en_w[i]),   0);
      chk("rst_wr_bank", i, int'(wr_bank_w[i]), 0);
      chk("rst_wr_addr", i, int'(wr_addr_w[i]), 0);
      chk("rst_wr_data", i, int'(wr_data_w[i]), 0);
      chk("rst_fv",      i, int'(fv_w[i]),      0);
      chk("rst_fb",      i, int'(fb_w[i]),      0);
      chk("rst_ovf",     i, int'(ovf_w[i]),     0);
      chk("rst_state",   i, int'(state_w[i]),   0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: per-cycle outputs against the cycle queue, writes against the write queue.
  initial begin
    cyc_t c;
    wr_t  w;
    wcnt[0] = 0; wcnt[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        for (int i = 0; i < 2; i++) begin
          if (cq[i].size() == 0) begin
            chk("cyc_queue_empty", i, 0, 1);
          end else begin
            c = cq[i].pop_front();
            chk("wr_en", i, int'(wr_en_w[i]), int'(c.wr));
            chk("frame_valid", i, int'(fv_w[i]), int'(c.fv));
            chk("frame_bank", i, int'(fb_w[i]), int'(c.fb));
            chk("overflow_cnt", i, int'(ovf_w[i]), int'(c.ovf));
            chk("state", i, int'(state_w[i]), int'(c.st));
          end
          if (wr_en_w[i]) begin
            wcnt[i]++;
            if (wq[i].size() == 0) begin
              chk("unexpected_write", i, 1, 0);
            end else begin
              w = wq[i].pop_front();
              chk("wr_bank", i, int'(wr_bank_w[i]), int'(w.bank));
              chk("wr_addr", i, int'(wr_addr_w[i]), int'(w.addr));
              chk("wr_data", i, int'(wr_data_w[i]), int'(w.data));
            end
          end
        end
      end
    end
  end

  initial begin
    int wbase;
    int off;
    reset_n = 1'b1; en = 1'b0; sample_valid = 1'b0; sample = '0;
    frame_ready[0] = 1'b0; frame_ready[1] = 1'b0;
    frame_done[0]  = 1'b0; frame_done[1]  = 1'b0;
    busy[0] = 0; busy[1] = 0;
    model_reset();
    do_reset();

    // Single frame fill
    cyc(1, 0, '0); cyc(1, 0, '0);
    for (int k = 0; k < 8; k++) cyc(1, 1, SW'(k));
    cyc(1, 0, '0); cyc(1, 0, '0);
    chk("fill_fv", 0, int'(fv_w[0]), 1);
    chk("fill_fb", 0, int'(fb_w[0]), 0);
    chk("fill_last_addr", 0, int'(wr_addr_w[0]), 7);

    // Ping-pong with overflow, then release
    do_reset();
    cyc(1, 0, '0); cyc(1, 0, '0);
    for (int k = 0; k < 24; k++) cyc(1, 1, SW'(16'h0100 + k));
    cyc(1, 0, '0); cyc(1, 0, '0); cyc(1, 0, '0);
    chk("pp_ovf", 0, int'(ovf_w[0]), 8);
    chk("pp_state", 0, int'(state_w[0]), 2);
    chk("pp_fb", 0, int'(fb_w[0]), 0);
    chk("pp_fv", 0, int'(fv_w[0]), 1);
    rdy_ov = 1'b1; cyc(1, 0, '0); rdy_ov = 1'b0;
    cyc(1, 0, '0);
    chk("pp_fv_fall", 0, int'(fv_w[0]), 0);
    dn_ov = 1'b1; cyc(1, 0, '0); dn_ov = 1'b0;
    cyc(1, 0, '0);
    chk("pp_fb_next", 0, int'(fb_w[0]), 1);
    chk("pp_fv_next", 0, int'(fv_w[0]), 1);
    chk("pp_state_resume", 0, int'(state_w[0]), 1);
    cyc(1, 1, 16'h0aa0); cyc(1, 1, 16'h0aa1); cyc(1, 0, '0);
    chk("pp_resume_bank", 0, int'(wr_bank_w[0]), 0);
    chk("pp_resume_addr", 0, int'(wr_addr_w[0]), 1);

    // Last sample of bank 0 coincides with release of bank 1
    rdy_ov = 1'b1; cyc(1, 0, '0); rdy_ov = 1'b0;
    cyc(1, 0, '0);
    chk("sim_reading", 0, int'(fv_w[0]), 0);
    for (int k = 2; k < 7; k++) cyc(1, 1, SW'(16'h0aa0 + k));
    dn_ov = 1'b1; cyc(1, 1, 16'h0aa7); dn_ov = 1'b0;
    cyc(1, 0, '0);
    chk("sim_state", 0, int'(state_w[0]), 1);
    chk("sim_ovf", 0, int'(ovf_w[0]), 8);
    cyc(1, 1, 16'h0bb0); cyc(1, 0, '0);
    chk("sim_new_bank", 0, int'(wr_bank_w[0]), 1);
    chk("sim_new_addr", 0, int'(wr_addr_w[0]), 0);

    // Decimation by 3
    do_reset();
    cyc(1, 0, '0); cyc(1, 0, '0);
    wbase = wcnt[1];
    for (int p = 1; p <= 24; p++) cyc(1, 1, SW'(p));
    cyc(1, 0, '0); cyc(1, 0, '0); cyc(1, 0, '0);
    chk("decim_writes", 1, wcnt[1] - wbase, 8);
    chk("decim_last_data", 1, int'(wr_data_w[1]), 22);
    chk("decim_last_addr", 1, int'(wr_addr_w[1]), 7);

    // Abort mid-frame
    do_reset();
    cyc(1, 0, '0); cyc(1, 0, '0);
    for (int k = 0; k < 5; k++) cyc(1, 1, SW'(16'h0200 + k));
    cyc(0, 0, '0); cyc(0, 0, '0);
    chk("abort_state", 0, int'(state_w[0]), 0);
    chk("abort_fv", 0, int'(fv_w[0]), 0);
    cyc(1, 0, '0); cyc(1, 0, '0);
    cyc(1, 1, 16'h0300); cyc(1, 0, '0);
    chk("abort_restart_addr", 0, int'(wr_addr_w[0]), 0);
    chk("abort_restart_bank", 0, int'(wr_bank_w[0]), 0);

    // Overflow saturation, then reset while filling
    do_reset();
    cyc(1, 0, '0); cyc(1, 0, '0);
    for (int k = 0; k < 316; k++) cyc(1, 1, SW'(k));
    cyc(1, 0, '0); cyc(1, 0, '0);
    chk("sat_ovf", 0, int'(ovf_w[0]), 255);
    chk("sat_ovf_decim", 1, int'(ovf_w[1]), 90);
    rdy_ov = 1'b1; cyc(1, 0, '0); rdy_ov = 1'b0;
    dn_ov = 1'b1; cyc(1, 0, '0); dn_ov = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1, 1, SW'(16'h0400 + k));
    cyc(1, 0, '0);
    chk("midfill_state", 0, int'(state_w[0]), 1);
    do_reset();

    // Randomized traffic against a randomly paced FFT
    auto_fft = 1'b1;
    off = 0;
    for (int n = 0; n < 3000; n++) begin
      bit e, v;
      if (off > 0) begin
        off--;
        e = 1'b0;
      end else begin
        e = 1'b1;
        if ($urandom_range(0, 99) == 0) off = $urandom_range(1, 4);
      end
      v = ($urandom_range(0, 1) == 1) && !(e && !en_prev);
      cyc(e, v, SW'($urandom));
    end
    auto_fft = 1'b0;
    cyc(0, 0, '0); cyc(0, 0, '0);
    @(posedge clk);
    #2;
    chk_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_cyc_q", i, cq[i].size(), 0);
      chk("drain_wr_q", i, wq[i].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
